// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of a UART transmitter.
//
// Bytes written on wr_en are stored in a DEPTH-entry circular buffer. A
// three-state drain FSM pops the head into tx_data whenever the queue is
// non-empty and the transmitter is idle, then holds tx_start until the
// transmitter acknowledges by raising tx_busy, and waits for tx_busy to fall
// before it may pop again.
//
// Handshake (tx_start / tx_busy): tx_start is a level request. Once raised,
// tx_start and tx_data stay constant until tx_busy is sampled high; tx_start
// then drops and the FSM waits for tx_busy to be sampled low. The
// transmitter may take any number of cycles to accept, so there is no
// timeout.
//
// full, empty and count are all registered and are recomputed from the same
// next-count value, so the three always agree. The count excludes the byte
// currently held in tx_data. flush empties the queue without touching the
// byte in flight and wins over a same-cycle write. rst wins over everything.
//
// fsm_state exposes the drain FSM state (IDLE=0, LAUNCH=1, WAIT_DONE=2).

module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [1:0]    fsm_state
);

  localparam int PW = CW - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Storage and queue bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;

  // Drain side
  state_t        state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;

  logic          push;
  logic          pop;

  // Write acceptance: uses the registered full flag, and flush suppresses
  // both the write and any overflow report for it.
  always_comb begin
    push       = 1'b0;
    overflow_d = 1'b0;
    if (!flush) begin
      push       = wr_en && !full_q;
      overflow_d = wr_en &&  full_q;
    end
  end

  // Drain FSM next-state, pop decision and transmitter outputs
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_start_d = 1'b0;
        // A flush in the same cycle wins: nothing queued may be launched.
        if (!empty_q && !tx_busy && !flush) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        // Transmitter loads only on its own baud tick; wait indefinitely.
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tx_start_d = 1'b0;
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // Pointer, count and flag next values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Buffer write; a push is only ever accepted when not full, so the entry
  // at the read pointer is never overwritten while it is still queued.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Queue state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Drain FSM state and transmitter output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH=16). tx_busy comes either from a directly
// driven level (man_busy) or from a small UART transmitter model that loads
// only on its baud tick and shifts a 10-bit frame; received frames are
// collected in rx_q. The model uses a short bit period so whole streams fit
// in a few thousand cycles.

module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BAUD  = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic          full, empty, overflow, tx_start;
  logic [CW-1:0] count;
  logic [7:0]    tx_data;
  logic [1:0]    fsm_state;
  logic          tx_busy;
  logic          man_busy = 1'b0;
  logic          model_en = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .fsm_state(fsm_state)
  );

  // UART transmitter model
  logic       m_busy = 1'b0;
  logic [9:0] m_sh = 10'h3ff;
  logic [9:0] m_rx = 10'h000;
  logic [9:0] frame;
  int         m_div = 0;
  int         m_bits = 0;
  logic [9:0] rx_q[$];

  assign tx_busy = model_en ? m_busy : man_busy;

  always @(posedge clk) begin
    if (!model_en) begin
      m_busy <= 1'b0;
      m_div  <= 0;
      m_bits <= 0;
    end else begin
      m_div <= (m_div == BAUD - 1) ? 0 : m_div + 1;
      if (m_div == BAUD - 1) begin
        if (!m_busy) begin
          if (tx_start) begin
            m_busy <= 1'b1;
            m_sh   <= {1'b1, tx_data, 1'b0};
            m_bits <= 0;
          end
        end else begin
          frame = {m_sh[0], m_rx[9:1]};
          m_rx   <= frame;
          m_sh   <= {1'b1, m_sh[9:1]};
          m_bits <= m_bits + 1;
          if (m_bits == 9) begin
            m_busy <= 1'b0;
            rx_q.push_back(frame);
          end
        end
      end
    end
  end

  // Monitors: longest run of idle-with-data cycles, and any overflow pulse
  logic mon_en = 1'b0;
  int   gap_run = 0;
  int   gap_max = 0;
  logic ovf_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (fsm_state == ST_IDLE && !empty && !tx_start) gap_run = gap_run + 1;
      else gap_run = 0;
      if (gap_run > gap_max) gap_max = gap_run;
      if (overflow) ovf_seen = 1'b1;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
  endtask

  task automatic test_single();
    man_busy = 1'b0;
    wr_data = 8'hA5;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    total++; if (count !== CW'(1)) begin bad++; $display("FAIL single_count_n1 got=%0d exp=1", count); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty_n1 got=%b exp=0", empty); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_n1 got=%b exp=0", tx_start); end
    tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_n2 got=%b exp=1", tx_start); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_n2 got=%h exp=a5", tx_data); end
    total++; if (count !== '0) begin bad++; $display("FAIL single_count_n2 got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_n2 got=%b exp=1", empty); end
    tick(); tick(); tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_hold got=%b exp=1", tx_start); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_hold got=%h exp=a5", tx_data); end
    man_busy = 1'b1;
    tick();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_drop got=%b exp=0", tx_start); end
    total++; if (fsm_state !== ST_WAIT) begin bad++; $display("FAIL single_state_wait got=%0d exp=%0d", fsm_state, ST_WAIT); end
    tick();
    man_busy = 1'b0;
    tick(); tick();
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_keep got=%h exp=a5", tx_data); end
    total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL single_state_idle got=%0d exp=%0d", fsm_state, ST_IDLE); end
  endtask

  // Fill with transmitter busy, overflow on 17th, then pop+write when full
  task automatic test_fill();
    man_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h20 + 8'(i);
      wr_en = 1'b1;
      tick();
    end
    total++; if (count !== CW'(16)) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL fill_busy_blocks got=%b exp=0", tx_start); end
    wr_data = 8'h30;
    tick();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf_pulse got=%b exp=1", overflow); end
    total++; if (count !== CW'(16)) begin bad++; $display("FAIL fill_count_after_ovf got=%0d exp=16", count); end
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_one_cycle got=%b exp=0", overflow); end
    man_busy = 1'b0;
    wr_data = 8'h55;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    total++; if (count !== CW'(15)) begin bad++; $display("FAIL simul_count got=%0d exp=15", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL simul_ovf got=%b exp=1", overflow); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL simul_full got=%b exp=0", full); end
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h20) begin bad++; $display("FAIL simul_launch got=%b/%h exp=1/20", tx_start, tx_data); end
    rx_q.delete();
    model_en = 1'b1;
    for (int k = 0; k < 3000 && rx_q.size() < 16; k++) tick();
    for (int k = 0; k < 200; k++) tick();
    total++; if (rx_q.size() != 16) begin bad++; $display("FAIL fill_rx_size got=%0d exp=16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== {1'b1, 8'h20 + 8'(i), 1'b0}) begin
        bad++; $display("FAIL fill_rx_byte%0d got=%h exp=%h", i, rx_q[i], {1'b1, 8'h20 + 8'(i), 1'b0});
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained_empty got=%b exp=1", empty); end
  endtask

  task automatic test_order();
    rx_q.delete();
    gap_max = 0; gap_run = 0; ovf_seen = 1'b0;
    mon_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 3000 && rx_q.size() < 16; k++) tick();
    mon_en = 1'b0;
    total++; if (rx_q.size() != 16) begin bad++; $display("FAIL order_rx_size got=%0d exp=16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== {1'b1, 8'(i + 1), 1'b0}) begin
        bad++; $display("FAIL order_byte%0d got=%h exp=%h", i, rx_q[i], {1'b1, 8'(i + 1), 1'b0});
      end
    end
    total++; if (gap_max > 1) begin bad++; $display("FAIL order_gap got=%0d exp<=1", gap_max); end
    total++; if (ovf_seen !== 1'b0) begin bad++; $display("FAIL order_ovf got=%b exp=0", ovf_seen); end
  endtask

  task automatic test_wrap();
    rx_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        wr_data = 8'h40 + 8'(b * 10 + i);
        wr_en = 1'b1;
        tick();
      end
      wr_en = 1'b0;
      for (int k = 0; k < 3000 && rx_q.size() < (b + 1) * 10; k++) tick();
    end
    tick(); tick();
    total++; if (rx_q.size() != 40) begin bad++; $display("FAIL wrap_rx_size got=%0d exp=40", rx_q.size()); end
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== {1'b1, 8'h40 + 8'(i), 1'b0}) begin
        bad++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, rx_q[i], {1'b1, 8'h40 + 8'(i), 1'b0});
      end
    end
    total++; if (count !== '0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush_reset();
    logic seen;
    model_en = 1'b0;
    man_busy = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h60 + 8'(i);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    total++; if (count !== CW'(5)) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    total++; if (count !== '0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL flush_flags got=%b/%b exp=1/0", empty, full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_no_ovf got=%b exp=0", overflow); end
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h60) begin bad++; $display("FAIL flush_inflight got=%b/%h exp=1/60", tx_start, tx_data); end
    man_busy = 1'b1;
    tick();
    man_busy = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (tx_start) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_start got=%b exp=0", seen); end
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h70 + 8'(i);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL rst_pre_launch got=%b exp=1", tx_start); end
    rst = 1'b1;
    flush = 1'b1;
    wr_en = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", tx_data); end
    total++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0d/%b/%b exp=0/1/0", count, empty, full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (tx_start) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_start got=%b exp=0", seen); end
    wr_data = 8'h77;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h77) begin bad++; $display("FAIL rst_refill got=%b/%h exp=1/77", tx_start, tx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_order();
    test_wrap();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entry count (power of two, 2..256).
REQ-002 SHALL provide parameter CW = $clog2(DEPTH)+1, derived, width of count output.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_en  input  1  enqueue request, single-cycle per byte.
REQ-007 flush  input  1  synchronous clear of queued (not in-flight) bytes.
REQ-008 full  output  1  count == DEPTH.
REQ-009 empty  output  1  count == 0.
REQ-010 count  output  CW  bytes currently queued, excluding in-flight byte.
REQ-011 overflow  output  1  one-cycle pulse: write dropped because full.
REQ-012 tx_data  output  8  byte presented to UART transmitter.
REQ-013 tx_start  output  1  launch request to UART transmitter.
REQ-014 tx_busy  input  1  transmitter busy (high from load until stop bit done).

Function
REQ-015 Storage SHALL be DEPTH x 8 circular buffer; read/write pointers of CW-1 bits, wrap modulo DEPTH.
REQ-016 Write accepted iff wr_en=1 and full=0 (registered value at cycle start); byte stored at write pointer, pointer+1.
REQ-017 wr_en=1 with full=1 SHALL drop the byte, leave state unchanged, pulse overflow next cycle for one cycle.
REQ-018 Simultaneous accepted write and pop SHALL leave count unchanged; pointers both advance.
REQ-019 full, empty, count SHALL be registered and consistent with each other every cycle.
REQ-020 Drain FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-021 IDLE: if empty=0 and tx_busy=0 -> pop head into tx_data, tx_start<=1, go LAUNCH; else stay, tx_start=0.
REQ-022 LAUNCH: hold tx_start=1 and tx_data stable until tx_busy=1 sampled; then tx_start<=0, go WAIT_DONE.
REQ-023 LAUNCH SHALL tolerate any number of cycles (transmitter only loads on its baud tick); no timeout.
REQ-024 WAIT_DONE: on tx_busy=0 sampled -> IDLE; next pop no earlier than following cycle.
REQ-025 tx_data SHALL change only on pop; holds last byte otherwise.
REQ-026 Latency: write accepted at cycle N into empty FIFO, FSM IDLE, tx_busy=0 -> count=1 at N+1, tx_start=1 with byte at N+2, count=0 at N+2.
REQ-027 flush=1 SHALL set pointers equal, count=0, empty=1, full=0 next cycle; in-flight byte (LAUNCH/WAIT_DONE) unaffected; flush has priority over same-cycle write (write dropped, no overflow pulse).
REQ-028 Pop SHALL never occur when empty=1; write never corrupts entry at read pointer while count=DEPTH.
REQ-029 tx_busy high in IDLE (e.g. transmitter post-reset guard) SHALL block launch until low.

Reset
REQ-030 rst=1 SHALL, next edge: pointers 0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, FSM IDLE.
REQ-031 rst mid-transfer SHALL discard queued and in-flight bytes; no tx_start until queue refilled after rst release.
REQ-032 rst SHALL take priority over flush, wr_en and all FSM transitions.

Verification
REQ-033 Single byte: write 8'hA5, tx_busy model low -> tx_start=1, tx_data=8'hA5 two cycles after write; held until tx_busy=1; then tx_start=0.
REQ-034 Fill: 17 writes with DEPTH=16, tx_busy held 1 -> full=1, count=16, one overflow pulse on 17th, 17th byte never transmitted.
REQ-035 Ordering: write 8'h01..8'h10 back-to-back to UART model (9600 baud, 12 MHz) -> serial output bytes 01..10 in order, no gaps beyond one IDLE cycle between bytes.
REQ-036 Wrap: write/drain 40 bytes in bursts of 10 -> all 40 received in order, count returns to 0, empty=1.
REQ-037 Simultaneous: full FIFO, pop and wr_en same cycle -> write dropped, overflow=1, count 16->15.
REQ-038 Flush/reset: 5 queued, one in LAUNCH, assert flush -> in-flight byte completes, count=0, no further tx_start; repeat with rst -> tx_start=0 next cycle, all outputs at reset values.
